// File: rtl/cache_pkg.sv
// Shared L1 cache definitions: line geometry and the line-transfer engine state encoding.
package cache_pkg;

    localparam int L1_OFFSET         = 5;
    localparam int L1_WORDS_PER_LINE = 8;
    localparam int L1_LINE_W         = 256;
    localparam int L1_WORD_IDX       = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_WAIT = 3'd2,
        RF_REQ  = 3'd3,
        RF_WAIT = 3'd4,
        DONE    = 3'd5
    } xfer_state_e;

endpackage

// File: rtl/l1_line_xfer.sv
// Serialises an optional victim writeback plus a line refill into 32-bit memory accesses
// and returns the assembled refill line to the L1 miss FSM as a single-cycle response.
module l1_line_xfer
    import cache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = L1_WORDS_PER_LINE,
    localparam int LINE_W        = WORD_W * WORDS_PER_LINE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wb,
    input  logic [ADDR_W-1:0] req_wb_addr,
    input  logic [LINE_W-1:0] req_wb_data,
    input  logic [ADDR_W-1:0] req_rf_addr,
    output logic              rsp_valid,
    output logic [LINE_W-1:0] rsp_rdata,
    output logic              l1_mem_valid,
    output logic              l1_mem_store,
    output logic [ADDR_W-1:0] l1_mem_addr,
    output logic [WORD_W-1:0] l1_mem_wdata,
    input  logic [WORD_W-1:0] mem_l1_rdata,
    input  logic              mem_l1_valid
);

    localparam int TAG_W = ADDR_W - L1_OFFSET;
    localparam logic [L1_WORD_IDX-1:0] LAST_WORD = L1_WORD_IDX'(WORDS_PER_LINE - 1);

    xfer_state_e              r_state;
    xfer_state_e              w_stateNext;
    logic [L1_WORD_IDX-1:0]   r_cnt;
    logic [L1_WORD_IDX-1:0]   w_cntNext;
    logic [TAG_W-1:0]         r_wbTag;
    logic [TAG_W-1:0]         r_rfTag;
    logic [LINE_W-1:0]        r_wbData;
    logic [LINE_W-1:0]        r_rspData;

    logic                     w_accept;
    logic                     w_ready;
    logic                     w_memValid;
    logic                     w_rspValid;
    logic                     w_unusedLowBits;

    assign w_accept        = req_valid && (r_state == IDLE);
    assign w_unusedLowBits = ^{req_wb_addr[L1_OFFSET-1:0], req_rf_addr[L1_OFFSET-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wbTag   <= '0;
            r_rfTag   <= '0;
            r_wbData  <= '0;
            r_rspData <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            if (w_accept) begin
                r_wbTag  <= req_wb_addr[ADDR_W-1:L1_OFFSET];
                r_rfTag  <= req_rf_addr[ADDR_W-1:L1_OFFSET];
                r_wbData <= req_wb_data;
            end
            if ((r_state == RF_WAIT) && mem_l1_valid) begin
                r_rspData[WORD_W*r_cnt +: WORD_W] <= mem_l1_rdata;
            end
        end
    end

    // Address/data stay on the bus through the WAIT state; only the valid pulse drops.
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_ready      = 1'b0;
        w_memValid   = 1'b0;
        w_rspValid   = 1'b0;
        l1_mem_store = 1'b0;
        l1_mem_addr  = '0;
        l1_mem_wdata = '0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (req_valid) begin
                    w_cntNext   = '0;
                    w_stateNext = req_wb ? WB_REQ : RF_REQ;
                end
            end
            WB_REQ: begin
                w_memValid   = 1'b1;
                l1_mem_store = 1'b1;
                l1_mem_addr  = {r_wbTag, r_cnt, 2'b00};
                l1_mem_wdata = r_wbData[WORD_W*r_cnt +: WORD_W];
                w_stateNext  = WB_WAIT;
            end
            WB_WAIT: begin
                l1_mem_store = 1'b1;
                l1_mem_addr  = {r_wbTag, r_cnt, 2'b00};
                l1_mem_wdata = r_wbData[WORD_W*r_cnt +: WORD_W];
                if (mem_l1_valid) begin
                    if (r_cnt == LAST_WORD) begin
                        w_cntNext   = '0;
                        w_stateNext = RF_REQ;
                    end else begin
                        w_cntNext   = r_cnt + 1'b1;
                        w_stateNext = WB_REQ;
                    end
                end
            end
            RF_REQ: begin
                w_memValid  = 1'b1;
                l1_mem_addr = {r_rfTag, r_cnt, 2'b00};
                w_stateNext = RF_WAIT;
            end
            RF_WAIT: begin
                l1_mem_addr = {r_rfTag, r_cnt, 2'b00};
                if (mem_l1_valid) begin
                    if (r_cnt == LAST_WORD) begin
                        w_stateNext = DONE;
                    end else begin
                        w_cntNext   = r_cnt + 1'b1;
                        w_stateNext = RF_REQ;
                    end
                end
            end
            DONE: begin
                w_rspValid  = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Gating with rst silences the bus in the very cycle reset is applied mid-transfer.
    assign req_ready    = w_ready    && !rst;
    assign l1_mem_valid = w_memValid && !rst;
    assign rsp_valid    = w_rspValid && !rst;
    assign rsp_rdata    = r_rspData;

endmodule

// File: tb/tb_l1_line_xfer.sv
// Scoreboard bench for l1_line_xfer: a latency-programmable word memory plus a monitor
// that checks every memory access and every refill response against queued expectations.
module tb_l1_line_xfer;
    import cache_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_wb;
    logic [31:0]  req_wb_addr;
    logic [255:0] req_wb_data;
    logic [31:0]  req_rf_addr;
    logic         rsp_valid;
    logic [255:0] rsp_rdata;
    logic         l1_mem_valid;
    logic         l1_mem_store;
    logic [31:0]  l1_mem_addr;
    logic [31:0]  l1_mem_wdata;
    logic [31:0]  mem_l1_rdata;
    logic         mem_l1_valid;

    l1_line_xfer #(.ADDR_W(32), .WORD_W(32), .WORDS_PER_LINE(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wb       (req_wb),
        .req_wb_addr  (req_wb_addr),
        .req_wb_data  (req_wb_data),
        .req_rf_addr  (req_rf_addr),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .l1_mem_valid (l1_mem_valid),
        .l1_mem_store (l1_mem_store),
        .l1_mem_addr  (l1_mem_addr),
        .l1_mem_wdata (l1_mem_wdata),
        .mem_l1_rdata (mem_l1_rdata),
        .mem_l1_valid (mem_l1_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        store;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        logic [255:0] line;
        int           cyc;
    } rsp_t;

    acc_t accQ[$];
    rsp_t rspQ[$];

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory model: latency per word index comes from latSeq, unwritten words read as addr>>2.
    logic        memValid  = 1'b0;
    logic        spurValid = 1'b0;
    logic [31:0] memRdata  = '0;
    logic [31:0] spurData  = '0;
    int          latSeq[3] = '{1, 1, 1};
    logic [31:0] memArr [logic [31:0]];
    bit          pend = 1'b0;
    int          cd = 0;
    logic [31:0] pendAddr = '0;
    bit          pendStore = 1'b0;

    assign mem_l1_valid = memValid | spurValid;
    assign mem_l1_rdata = spurValid ? spurData : memRdata;

    always @(negedge clk) begin
        memValid = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (cd == 0) begin
                    memValid = 1'b1;
                    if (pendStore) memRdata = 32'h0;
                    else if (memArr.exists(pendAddr)) memRdata = memArr[pendAddr];
                    else memRdata = pendAddr >> 2;
                    pend = 1'b0;
                end else begin
                    cd--;
                end
            end
            if (l1_mem_valid) begin
                checkOutput("oneOutstanding", {255'b0, pend}, 256'b0);
                pend      = 1'b1;
                cd        = latSeq[int'(l1_mem_addr[4:2]) % 3] - 1;
                pendAddr  = l1_mem_addr;
                pendStore = l1_mem_store;
                if (l1_mem_store) memArr[l1_mem_addr] = l1_mem_wdata;
            end
        end
    end

    // Monitor: every bus pulse and every response is matched against the scoreboard queues.
    always @(negedge clk) begin
        acc_t e;
        rsp_t r;
        if (!rst) begin
            if (l1_mem_valid) begin
                if (accQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpectedMemReq: got addr %0h store %0b, expected none", l1_mem_addr, l1_mem_store);
                end else begin
                    e = accQ.pop_front();
                    checkOutput("memStore", {255'b0, l1_mem_store}, {255'b0, e.store});
                    checkOutput("memAddr", {224'b0, l1_mem_addr}, {224'b0, e.addr});
                    if (e.store) checkOutput("memWdata", {224'b0, l1_mem_wdata}, {224'b0, e.wdata});
                end
            end
            if (rsp_valid) begin
                if (rspQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpectedRsp: got line %0h, expected none", rsp_rdata);
                end else begin
                    r = rspQ.pop_front();
                    checkOutput("rspLine", rsp_rdata, r.line);
                    checkOutput("rspCycle", 256'(cyc), 256'(r.cyc));
                    checkOutput("readyLowInDone", {255'b0, req_ready}, 256'b0);
                end
            end
        end
    end

    task automatic applyStimulus(input bit wb, input logic [31:0] wbAddr, input logic [31:0] wbBase,
                                 input logic [31:0] rfAddr, input logic [31:0] expBase,
                                 input int expDelay, input int nLoads, input bit hold,
                                 output int hCyc);
        logic [255:0] wbLine;
        logic [255:0] expLine;
        logic [2:0]   wi;
        rsp_t         r;
        int           n;
        for (int i = 0; i < 8; i++) begin
            wi = 3'(i);
            wbLine[32*i +: 32]  = wbBase + 32'(i);
            expLine[32*i +: 32] = expBase + 32'(i);
            if (wb) accQ.push_back('{1'b1, {wbAddr[31:5], wi, 2'b00}, wbBase + 32'(i)});
        end
        for (int i = 0; i < nLoads; i++) begin
            wi = 3'(i);
            accQ.push_back('{1'b0, {rfAddr[31:5], wi, 2'b00}, 32'h0});
        end
        @(negedge clk);
        req_valid   = 1'b1;
        req_wb      = wb;
        req_wb_addr = wbAddr;
        req_wb_data = wbLine;
        req_rf_addr = rfAddr;
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL acceptTimeout: got req_ready 0 for %0d cycles, expected 1", n);
        end
        hCyc = cyc;
        if (nLoads == 8) begin
            r.line = expLine;
            r.cyc  = cyc + expDelay;
            rspQ.push_back(r);
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((accQ.size() != 0 || rspQ.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 256'(accQ.size() + rspQ.size()), 256'b0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hA, hB, h, k, n;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_wb      = 1'b0;
        req_wb_addr = '0;
        req_wb_data = '0;
        req_rf_addr = '0;

        repeat (3) @(negedge clk);
        checkOutput("rstReqReady", {255'b0, req_ready}, 256'b0);
        checkOutput("rstMemValid", {255'b0, l1_mem_valid}, 256'b0);
        checkOutput("rstRspValid", {255'b0, rsp_valid}, 256'b0);
        checkOutput("rstMemStore", {255'b0, l1_mem_store}, 256'b0);
        checkOutput("rstMemAddr", {224'b0, l1_mem_addr}, 256'b0);
        checkOutput("rstMemWdata", {224'b0, l1_mem_wdata}, 256'b0);
        checkOutput("rstRspData", rsp_rdata, 256'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idleReqReady", {255'b0, req_ready}, 256'd1);

        // Spurious completion in IDLE must not start anything or touch the line.
        spurValid = 1'b1;
        spurData  = 32'hFACE_0001;
        @(negedge clk);
        spurValid = 1'b0;
        @(negedge clk);
        checkOutput("spurIdleMemValid", {255'b0, l1_mem_valid}, 256'b0);
        checkOutput("spurIdleRspData", rsp_rdata, 256'b0);

        latSeq = '{1, 1, 1};
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0000_1234, 32'h488, 17, 8, 1'b0, h);
        waitDrain("refillOnlyDrain");

        applyStimulus(1'b1, 32'h0000_2000, 32'hA0, 32'h0000_3000, 32'hC00, 33, 8, 1'b0, h);
        waitDrain("wbRefillDrain");

        latSeq = '{1, 3, 5};
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0000_5040, 32'h1410, 31, 8, 1'b0, h);
        waitDrain("varLatencyDrain");

        latSeq = '{1, 1, 1};
        applyStimulus(1'b1, 32'h0000_4000, 32'hB0, 32'h0000_4000, 32'hB0, 33, 8, 1'b0, h);
        waitDrain("sameLineDrain");

        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0000_6000, 32'h1800, 17, 8, 1'b1, hA);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0000_7020, 32'h1C08, 17, 8, 1'b0, hB);
        checkOutput("backToBackAccept", 256'(hB), 256'(hA + 18));
        waitDrain("backToBackDrain");

        // Reset right after the fourth refill word lands.
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0000_8000, 32'h2000, 17, 4, 1'b0, h);
        k = 0;
        n = 0;
        while (k < 4 && n < 200) begin
            @(posedge clk);
            if (mem_l1_valid) k++;
            n++;
        end
        checkOutput("midRefillWordsSeen", 256'(k), 256'd4);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abortMemValid", {255'b0, l1_mem_valid}, 256'b0);
        checkOutput("abortRspValid", {255'b0, rsp_valid}, 256'b0);
        checkOutput("abortReqReady", {255'b0, req_ready}, 256'b0);
        @(negedge clk);
        rst       = 1'b0;
        spurValid = 1'b1;
        spurData  = 32'hDEAD_BEEF;
        @(negedge clk);
        spurValid = 1'b0;
        checkOutput("postRstReqReady", {255'b0, req_ready}, 256'd1);
        checkOutput("staleRspData", rsp_rdata, 256'b0);
        repeat (3) @(negedge clk);
        checkOutput("finalQueues", 256'(accQ.size() + rspQ.size()), 256'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/l1_line_xfer.md
Name: l1_line_xfer

Overview:
- Line-transfer engine directly downstream of the L1 data cache miss FSM.
- Accepts one line-level request per miss: an optional dirty-victim writeback plus a mandatory refill.
- Serialises each request into 32-bit word accesses on the word-wide main-memory interface.
- Returns the assembled 256-bit refill line to the cache in a single-cycle response.

Parameters:
- ADDR_W, 32, byte-address width.
- WORD_W, 32, memory word width.
- WORDS_PER_LINE, 8, words per cache line (LINE_W = WORD_W*WORDS_PER_LINE = 256).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  cache presents a miss request.
- req_ready  out  1  block can accept a request.
- req_wb  in  1  1 = write back victim line before refill.
- req_wb_addr  in  ADDR_W  victim line address (low 5 bits ignored).
- req_wb_data  in  LINE_W  victim line data, word i at bits [32i+:32].
- req_rf_addr  in  ADDR_W  refill line address (low 5 bits ignored).
- rsp_valid  out  1  refill line ready, one-cycle pulse.
- rsp_rdata  out  LINE_W  refill line, word i at bits [32i+:32].
- l1_mem_valid  out  1  word request to memory, one-cycle pulse.
- l1_mem_store  out  1  0 = load, 1 = store.
- l1_mem_addr  out  ADDR_W  word byte-address, low 2 bits 0.
- l1_mem_wdata  out  WORD_W  store data.
- mem_l1_rdata  in  WORD_W  load data.
- mem_l1_valid  in  1  memory completion (load data or store ack), latency >= 1 cycle.

Behaviour:
- Reset: rst is sampled on posedge clk only. Outputs during and after reset: state = IDLE, req_ready = 0 while rst = 1, rsp_valid = 0, rsp_rdata = 0, l1_mem_valid = 0, l1_mem_store = 0, l1_mem_addr = 0, l1_mem_wdata = 0, word counter = 0.
- Reset mid-operation: abort immediately, no further memory pulses, partial line discarded. A late mem_l1_valid arriving in IDLE is ignored.
- States: IDLE, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, DONE.
- IDLE: req_ready = 1. On req_valid & req_ready, capture all req_* fields and clear the counter. Next state is WB_REQ if req_wb = 1, else RF_REQ. Request fields are ignored when req_ready = 0.
- WB_REQ: drive l1_mem_valid = 1, l1_mem_store = 1, l1_mem_addr = {wb_addr[31:5], cnt, 2'b00}, l1_mem_wdata = wb_data[32*cnt +: 32]. Go to WB_WAIT.
- WB_WAIT: hold outputs (l1_mem_valid = 0) until mem_l1_valid.
  - On mem_l1_valid with cnt = 7: clear cnt, go to RF_REQ.
  - Otherwise: cnt++, go to WB_REQ.
- RF_REQ: drive l1_mem_valid = 1, l1_mem_store = 0, l1_mem_addr = {rf_addr[31:5], cnt, 2'b00}. Go to RF_WAIT.
- RF_WAIT: on mem_l1_valid, write mem_l1_rdata into rsp_rdata[32*cnt +: 32].
  - If cnt = 7: go to DONE.
  - Otherwise: cnt++, go to RF_REQ.
- DONE: rsp_valid = 1 for exactly one cycle, rsp_rdata stable and held until the next refill overwrites it. Return to IDLE.
- mem_l1_valid is sampled only in WB_WAIT/RF_WAIT and ignored in all other states. Exactly one memory access is outstanding at any time.
- Ordering: words are always transferred 0 to 7, ascending. The writeback fully completes before the first refill load, so read-after-write to the same line is safe.
- Counter: 3 bits, wraps 7 to 0 only on the WB to RF transition.
- Latency (handshake at cycle 0, memory latency L): refill-only rsp_valid at cycle 1 + 8(L+1). With writeback, rsp_valid at cycle 1 + 16(L+1). For L = 1 these are 17 and 33.
- req_ready = 0 in every state except IDLE. Back-to-back requests are therefore spaced by at least one IDLE cycle after DONE.

Decomposition:
- cache_pkg gains:
  - L1_WORDS_PER_LINE = 8
  - L1_LINE_W = 256
  - L1_WORD_IDX = 3
  - typedef enum logic [2:0] xfer_state_e {IDLE, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, DONE}
- Reuses the existing L1_OFFSET.
- Single module; no sub-module warranted. Counter and line assembly register live inline.

Test Plan:
- Refill-only: rf_addr = 0x0000_1234, memory returns addr>>2, L = 1 -> loads at 0x1220, 0x1224 … 0x123C; rsp_valid at cycle 17; rsp_rdata word i = 0x488+i.
- Writeback+refill: wb_addr = 0x0000_2000, wb_data word i = 0xA0+i, rf_addr = 0x0000_3000 -> 8 stores (0x2000…0x201C, data 0xA0…0xA7) precede any load; rsp_valid at cycle 33.
- Variable latency: memory L cycling 1/3/5 -> exactly one l1_mem_valid pulse per word, no pulse while waiting, correct line assembled.
- Reset mid-refill: assert rst after word 3 completes -> next cycle l1_mem_valid = 0, rsp_valid = 0, req_ready = 0; after deassert req_ready = 1. A stale mem_l1_valid does not alter rsp_rdata.
- Handshake: req_valid held high through DONE -> second request accepted only in the IDLE cycle after rsp_valid. Spurious mem_l1_valid in IDLE is ignored.
- Same-line writeback then refill (wb_addr = rf_addr = 0x4000): refill returns the just-written data.
